// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   Execute stage of a five-stage RV32 pipeline. It selects the forwarded
//   operands and runs the ALU. It resolves BEQ into a combinational redirect
//   for Fetch (PCSrcE, PCTargetE). It also registers the results into the
//   EX/MEM pipeline register.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE
//                       : decoded control for the instruction in EX
//   RD1E, RD2E, ImmExtE : register operands and sign-extended immediate
//   PCE, PCPlus4E, RDE  : instruction PC, PC+4, destination index
//   ResultW             : writeback result (forwarding source 01)
//   ForwardAE/BE        : forwarding selects (00/11 reg file, 01 WB, 10 MEM)
//   PCSrcE, PCTargetE   : branch taken / branch target, combinational
//   *M outputs          : EX/MEM pipeline register contents
//
// Handshake: there is none. The EX/MEM register loads every cycle unless
// rst is high. Reset takes priority over the load.
// ---------------------------------------------------------------------------
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RDE,
  input  logic [31:0] ResultW,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RDM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic        reg_write_q, mem_write_q, result_src_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_result_q, write_data_q, pc_plus4_q;

  logic [31:0] src_a_e, write_data_e, src_b_e, alu_result_e;
  logic        zero_e;

  // Operand forwarding. Select 10 takes this block's own EX/MEM register,
  // so a dependent instruction right behind its producer needs no bubble.
  always_comb begin
    src_a_e = RD1E;
    case (ForwardAE)
      2'b01:   src_a_e = ResultW;
      2'b10:   src_a_e = alu_result_q;
      default: src_a_e = RD1E;
    endcase
  end

  always_comb begin
    write_data_e = RD2E;
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = alu_result_q;
      default: write_data_e = RD2E;
    endcase
  end

  // Store data is taken before the immediate mux.
  assign src_b_e = ALUSrcE ? ImmExtE : write_data_e;

  always_comb begin
    alu_result_e = 32'h0;
    case (ALUControlE)
      3'b000:  alu_result_e = src_a_e + src_b_e;
      3'b001:  alu_result_e = src_a_e - src_b_e;
      3'b010:  alu_result_e = src_a_e & src_b_e;
      3'b011:  alu_result_e = src_a_e | src_b_e;
      3'b101:  alu_result_e = {31'h0, ($signed(src_a_e) < $signed(src_b_e))};
      default: alu_result_e = 32'h0;
    endcase
  end

  assign zero_e    = (alu_result_e == 32'h0);
  // The redirect is not gated by rst and always follows the current inputs.
  assign PCSrcE    = BranchE & zero_e;
  assign PCTargetE = PCE + ImmExtE;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= 5'h0;
      alu_result_q <= 32'h0;
      write_data_q <= 32'h0;
      pc_plus4_q   <= 32'h0;
    end else begin
      reg_write_q  <= RegWriteE;
      mem_write_q  <= MemWriteE;
      result_src_q <= ResultSrcE;
      rd_q         <= RDE;
      alu_result_q <= alu_result_e;
      write_data_q <= write_data_e;
      pc_plus4_q   <= PCPlus4E;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RDM        = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RV32 pipeline, sitting between the Decode stage's ID/EX outputs and the Memory stage. It selects forwarded operands, performs the ALU operation, computes the branch target and taken decision, and registers the results into the EX/MEM pipeline register. Branch redirect (PCSrcE, PCTargetE) goes back to Fetch combinationally in the same cycle.

## Interface
Parameters: none; datapath fixed at 32 bits, register index at 5 bits.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- RegWriteE  in  1  register-file write enable for this instruction
- ALUSrcE  in  1  ALU operand B select: 0 = forwarded RD2, 1 = ImmExtE
- MemWriteE  in  1  data-memory write enable
- ResultSrcE  in  1  writeback select: 0 = ALU result, 1 = memory read data
- BranchE  in  1  instruction is BEQ
- ALUControlE  in  3  ALU operation code
- RD1E, RD2E  in  32  register-file read data
- ImmExtE  in  32  sign-extended immediate
- PCE, PCPlus4E  in  32  instruction PC and PC+4
- RDE  in  5  destination register index
- ResultW  in  32  writeback-stage result, forwarding source
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit
- PCSrcE  out  1  branch taken, combinational
- PCTargetE  out  32  PCE + ImmExtE, combinational
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered control
- RDM  out  5  registered destination index
- ALUResultM  out  32  registered ALU result
- WriteDataM  out  32  registered store data (forwarded operand B before the immediate mux)
- PCPlus4M  out  32  registered PC+4

## Operation
- Operand A (SrcAE): ForwardAE 00 = RD1E, 01 = ResultW, 10 = ALUResultM (this block's own register output), 11 = RD1E.
- Forwarded B (WriteDataE): same encoding using ForwardBE and RD2E.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU (ALUControlE):
  - 000 = add
  - 001 = sub
  - 010 = and
  - 011 = or
  - 101 = set-less-than, signed; result is 32'h1 or 32'h0
  - 100, 110, 111 = result 0
- Add and sub are modulo 2^32. There is no overflow flag.
- ZeroE = (ALU result == 0).
- PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + ImmExtE, modulo 2^32.
- EX/MEM register: on each rising edge with rst = 0, RegWriteM, MemWriteM, ResultSrcM, RDM, ALUResultM, WriteDataM and PCPlus4M capture RegWriteE, MemWriteE, ResultSrcE, RDE, the ALU result, WriteDataE and PCPlus4E.
- No stall or flush inputs. The register loads every cycle.

## Timing
- Latency: EX/MEM outputs are one cycle after the inputs; PCSrcE and PCTargetE are zero-cycle combinational.
- Reset: on a rising edge with rst = 1, every registered output clears to 0: RegWriteM, MemWriteM, ResultSrcM, RDM, ALUResultM, WriteDataM, PCPlus4M. Reset has priority over capture.
- Reset asserted mid-stream: the instruction in EX at that edge is discarded. The first instruction captured after rst deasserts appears on the M outputs one cycle later.
- PCSrcE and PCTargetE are not gated by rst; they follow the current inputs.
- Back-to-back dependency with ForwardAE = 10: the operand comes from the current ALUResultM, i.e. the previous instruction's result, with no bubble.
- Forwarding from ALUResultM immediately after reset yields 0.

## Test plan
- Reset: hold rst = 1 for 2 edges with nonzero inputs -> all M outputs 0. Release rst with RD1E = 5, RD2E = 3, ALUSrcE = 0, ALUControlE = 000 -> ALUResultM = 8 one edge later.
- ALU ops with RD1E = 32'hFFFFFFFF and RD2E = 1:
  - add -> 0
  - sub -> 32'hFFFFFFFE
  - and -> 1
  - or -> 32'hFFFFFFFF
  - slt -> 1 (signed -1 < 1)
  - code 111 -> 0
- Immediate and store data: ALUSrcE = 1, ImmExtE = 32'h10, RD1E = 32'h100, RD2E = 32'hABCD, MemWriteE = 1 -> ALUResultM = 32'h110, WriteDataM = 32'hABCD, MemWriteM = 1.
- Branch taken: BranchE = 1, RD1E = RD2E = 7, ALUControlE = 001, PCE = 32'h20, ImmExtE = 32'hFFFFFFF8 -> PCSrcE = 1 and PCTargetE = 32'h18 in the same cycle. With RD2E = 6 -> PCSrcE = 0.
- Forwarding:
  - Cycle 1: add with result 9.
  - Cycle 2: ForwardAE = 10, RD1E = 0, RD2E = 1, add -> ALUResultM = 10.
  - ForwardBE = 01 with ResultW = 32'h55 -> WriteDataM = 32'h55.
  - ForwardAE = 11 -> RD1E is used.
- Pass-through: RDE = 5'h1F, PCPlus4E = 32'h0000000C, ResultSrcE = 1, RegWriteE = 1 -> RDM = 5'h1F, PCPlus4M = 32'hC, ResultSrcM = 1, RegWriteM = 1 after one edge.
